seletor_jogador: RTL and testbench
==================================

# seletor_jogador

Parametrised player-selection register: converts a bank of per-player push-buttons plus one "skip" button into a registered player index for the voting and night-action stages of the game FSM. It debounces the button pattern, rejects multi-press and eliminated-player presses, emits one-cycle valid/invalid strobes, and requires full release before the next selection. With N_JOGADORES=5 the index encoding (players 0-4, skip = 5, none = 7) is identical to the existing 5+1 button converter, so it is a drop-in successor.

## Interface
- N_JOGADORES, 5: number of player buttons (>= 2).
- DEBOUNCE_CICLOS, 4: consecutive clock edges a pattern must be sampled unchanged before it is accepted (>= 1).
- W (local), $clog2(N_JOGADORES+2): index width. Codes: 0..N_JOGADORES-1 = player, N_JOGADORES = PULAR (skip), all-ones = NENHUM (no selection).

- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- botoes_jogadores  in  N_JOGADORES+1  button levels, already synchronised; bit i = player i, MSB = skip.
- habilita  in  1  selection window open; presses ignored while low.
- jogadores_vivos  in  N_JOGADORES  bit i high = player i may be chosen.
- permite_pular  in  1  skip button accepted when high.
- limpa  in  1  synchronous clear of the held selection.
- jogador_escolhido  out  W  last accepted index, held until next acceptance or clear.
- escolha_valida  out  1  one-cycle strobe: jogador_escolhido updated this cycle.
- escolha_invalida  out  1  one-cycle strobe: stable pattern rejected.
- ocupado  out  1  high in FILTRO or SOLTURA.

## Operation
- Registers: estado, amostra (N_JOGADORES+1 bits), cont ($clog2(DEBOUNCE_CICLOS+1) bits), jogador_escolhido, both strobes.
- Reset (reset low, async): estado=ESPERA, amostra=0, cont=0, jogador_escolhido=NENHUM, escolha_valida=0, escolha_invalida=0; ocupado=0.
- Strobes default to 0 every cycle; set only by the decision below.
- limpa high: jogador_escolhido=NENHUM, estado=ESPERA, cont=0, no strobe; overrides all other activity that edge.
- ESPERA: if habilita and botoes_jogadores != 0: amostra=botoes, cont=1; if DEBOUNCE_CICLOS==1 decide immediately and go SOLTURA, else go FILTRO. Otherwise stay.
- FILTRO: if habilita low -> ESPERA (abort, no strobe). Else if botoes != amostra (including all-released) -> ESPERA, no strobe. Else cont=cont+1; when cont+1 == DEBOUNCE_CICLOS decide and go SOLTURA.
- Decision on amostra: valid iff exactly one bit set AND (player bit i with jogadores_vivos[i]=1, OR skip bit with permite_pular=1), sampled that same edge. Valid -> jogador_escolhido = i or PULAR, escolha_valida=1. Invalid (multi-bit, dead player, skip disallowed) -> escolha_invalida=1, jogador_escolhido unchanged.
- SOLTURA: stay until botoes_jogadores == 0 sampled at an edge, then ESPERA. habilita is ignored here; a held button never produces a second decision.
- ocupado is combinational from estado.

## Timing
- Press sampled first at edge E0 (in ESPERA): decision registered at edge E0+(DEBOUNCE_CICLOS-1); strobe visible for exactly the following cycle.
- Any pattern change or habilita drop before that edge restarts from ESPERA; new press needs full DEBOUNCE_CICLOS again.
- Release observed at edge Er in SOLTURA -> ESPERA after Er; a new press can be sampled at Er+1 earliest.
- limpa concurrent with a deciding edge: limpa wins, no strobe, output NENHUM.
- reset asserted mid-FILTRO/SOLTURA: immediate return to reset values, no strobe.
- jogadores_vivos/permite_pular only matter at the deciding edge.

## Test plan
- N=5, D=4, all alive: hold bit 2 for 6 cycles -> escolha_valida pulses once at 4th edge, jogador_escolhido=3'b010, ocupado high until release +1 edge.
- Hold bit 1 for 2 cycles, release, re-press for 4 -> no strobe after first press, one valid strobe with 3'b001 after second.
- Press bits 0 and 3 together 4 cycles -> escolha_invalida pulse, jogador_escolhido stays 3'b111; press bit 4 with jogadores_vivos[4]=0 -> escolha_invalida, value unchanged.
- Skip (bit 5): permite_pular=1 -> valid, 3'b101; permite_pular=0 -> invalid. Keep held 20 cycles -> no repeat strobe.
- limpa asserted on the deciding edge -> no strobe, output 3'b111; habilita dropped mid-filter -> return to ESPERA, no strobe.
- N=8, D=1 (W=4): single-cycle press of bit 7 -> valid next cycle, output 4'b0111; skip -> 4'b1000; reset low asynchronously mid-SOLTURA -> output 4'b1111, ocupado 0 immediately.

Source files
------------

// File: rtl/seletor_jogador_if.sv
// Signal bundle between the game FSM and the player-selection register.
interface seletor_jogador_if #(
  parameter int N_JOGADORES = 5
);
  localparam int W = $clog2(N_JOGADORES + 2);

  logic [N_JOGADORES:0]   botoes_jogadores;
  logic                   habilita;
  logic [N_JOGADORES-1:0] jogadores_vivos;
  logic                   permite_pular;
  logic                   limpa;
  logic [W-1:0]           jogador_escolhido;
  logic                   escolha_valida;
  logic                   escolha_invalida;
  logic                   ocupado;
  logic [1:0]             estado_dbg;

  // escolha_valida / escolha_invalida are single-cycle strobes with no back-pressure:
  // the consumer must sample them on the cycle they are high; jogador_escolhido is
  // already updated in that same cycle and holds until the next acceptance or limpa.
  modport master (
    output botoes_jogadores, habilita, jogadores_vivos, permite_pular, limpa,
    input  jogador_escolhido, escolha_valida, escolha_invalida, ocupado, estado_dbg
  );

  modport slave (
    input  botoes_jogadores, habilita, jogadores_vivos, permite_pular, limpa,
    output jogador_escolhido, escolha_valida, escolha_invalida, ocupado, estado_dbg
  );
endinterface

// File: rtl/seletor_jogador.sv
// Debounced player-selection register: one-hot button pattern -> held player index,
// with valid/invalid strobes and a mandatory full release between selections.
module seletor_jogador #(
  parameter int N_JOGADORES     = 5,
  parameter int DEBOUNCE_CICLOS = 4
) (
  input logic              clock,
  input logic              reset,
  seletor_jogador_if.slave bus
);
  localparam int W  = $clog2(N_JOGADORES + 2);
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [W-1:0]         NENHUM = '1;
  localparam logic [N_JOGADORES:0] UM     = (N_JOGADORES + 1)'(1);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    FILTRO  = 2'd1,
    SOLTURA = 2'd2
  } estado_t;

  estado_t              estado_q;
  logic [N_JOGADORES:0] amostra_q;
  logic [CW-1:0]        cont_q;
  logic [CW-1:0]        cont_d;
  logic [W-1:0]         escolhido_q;
  logic                 valida_q;
  logic                 invalida_q;

  logic [N_JOGADORES:0] botoes;
  logic [W-1:0]         idx;
  logic                 unico;
  logic                 aceita;

  assign botoes = bus.botoes_jogadores;
  assign cont_d = cont_q + CW'(1);

  // The decision only fires while the live pattern equals amostra_q, so it can be
  // evaluated on the live buttons directly.
  always_comb begin
    idx = '0;
    for (int i = 0; i <= N_JOGADORES; i++) begin
      if (botoes[i]) idx = W'(i);
    end
    unico  = (botoes != '0) && ((botoes & (botoes - UM)) == '0);
    aceita = unico && (botoes[N_JOGADORES] ? bus.permite_pular
                                           : |(botoes[N_JOGADORES-1:0] & bus.jogadores_vivos));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= ESPERA;
      amostra_q   <= '0;
      cont_q      <= '0;
      escolhido_q <= NENHUM;
      valida_q    <= 1'b0;
      invalida_q  <= 1'b0;
    end else begin
      valida_q   <= 1'b0;
      invalida_q <= 1'b0;
      if (bus.limpa) begin
        escolhido_q <= NENHUM;
        estado_q    <= ESPERA;
        cont_q      <= '0;
      end else begin
        case (estado_q)
          ESPERA: begin
            if (bus.habilita && (botoes != '0)) begin
              amostra_q <= botoes;
              cont_q    <= CW'(1);
              if (DEBOUNCE_CICLOS == 1) begin
                if (aceita) begin
                  escolhido_q <= idx;
                  valida_q    <= 1'b1;
                end else begin
                  invalida_q  <= 1'b1;
                end
                estado_q <= SOLTURA;
              end else begin
                estado_q <= FILTRO;
              end
            end
          end
          FILTRO: begin
            if (!bus.habilita || (botoes != amostra_q)) begin
              estado_q <= ESPERA;
            end else begin
              cont_q <= cont_d;
              if (cont_d == CW'(DEBOUNCE_CICLOS)) begin
                if (aceita) begin
                  escolhido_q <= idx;
                  valida_q    <= 1'b1;
                end else begin
                  invalida_q  <= 1'b1;
                end
                estado_q <= SOLTURA;
              end
            end
          end
          SOLTURA: begin
            if (botoes == '0) estado_q <= ESPERA;
          end
          default: estado_q <= ESPERA;
        endcase
      end
    end
  end

  assign bus.jogador_escolhido = escolhido_q;
  assign bus.escolha_valida    = valida_q;
  assign bus.escolha_invalida  = invalida_q;
  assign bus.ocupado           = (estado_q == FILTRO) || (estado_q == SOLTURA);
  assign bus.estado_dbg        = estado_q;
endmodule

// File: tb/tb_seletor_jogador.sv
// Directed bench for seletor_jogador: N=5/D=4 instance plus an N=8/D=1 instance.
module tb_seletor_jogador;
  logic clk;
  logic rst_n;
  logic rst2_n;
  int   n_checks;
  int   n_errors;
  int   strobes;

  seletor_jogador_if #(.N_JOGADORES(5)) bus ();
  seletor_jogador_if #(.N_JOGADORES(8)) bus2 ();

  seletor_jogador #(.N_JOGADORES(5), .DEBOUNCE_CICLOS(4)) dut (
    .clock(clk), .reset(rst_n), .bus(bus.slave)
  );
  seletor_jogador #(.N_JOGADORES(8), .DEBOUNCE_CICLOS(1)) dut2 (
    .clock(clk), .reset(rst2_n), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are inspected 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    bus.botoes_jogadores = '0; bus.habilita = 1'b1; bus.jogadores_vivos = 5'b11111;
    bus.permite_pular = 1'b1; bus.limpa = 1'b0;
    bus2.botoes_jogadores = '0; bus2.habilita = 1'b1; bus2.jogadores_vivos = 8'hFF;
    bus2.permite_pular = 1'b1; bus2.limpa = 1'b0;
    tick(); tick();
    n_checks++;
    if (bus.jogador_escolhido !== 3'b111 || bus.escolha_valida !== 1'b0 ||
        bus.escolha_invalida !== 1'b0 || bus.ocupado !== 1'b0 || bus.estado_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL reset: idx=%b v=%b i=%b oc=%b st=%0d required idx=111 v=0 i=0 oc=0 st=0",
               bus.jogador_escolhido, bus.escolha_valida, bus.escolha_invalida, bus.ocupado, bus.estado_dbg);
    end
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();
  endtask

  task automatic test_valid_press();
    strobes = 0;
    bus.botoes_jogadores = 6'b000100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (bus.escolha_valida) strobes++;
      if (c == 4) begin
        n_checks++;
        if (bus.escolha_valida !== 1'b1 || bus.jogador_escolhido !== 3'b010) begin
          n_errors++;
          $display("FAIL valid_press_edge4: v=%b idx=%b required v=1 idx=010",
                   bus.escolha_valida, bus.jogador_escolhido);
        end
      end
    end
    n_checks++;
    if (strobes != 1 || bus.ocupado !== 1'b1) begin
      n_errors++;
      $display("FAIL valid_press_once: strobes=%0d oc=%b required strobes=1 oc=1", strobes, bus.ocupado);
    end
    bus.botoes_jogadores = '0;
    tick();
    n_checks++;
    if (bus.ocupado !== 1'b0 || bus.jogador_escolhido !== 3'b010) begin
      n_errors++;
      $display("FAIL valid_release: oc=%b idx=%b required oc=0 idx=010", bus.ocupado, bus.jogador_escolhido);
    end
  endtask

  task automatic test_short_press();
    strobes = 0;
    bus.botoes_jogadores = 6'b000010;
    tick(); tick();
    bus.botoes_jogadores = '0;
    tick();
    if (bus.escolha_valida || bus.escolha_invalida) strobes++;
    n_checks++;
    if (strobes != 0 || bus.ocupado !== 1'b0) begin
      n_errors++;
      $display("FAIL short_press: strobes=%0d oc=%b required strobes=0 oc=0", strobes, bus.ocupado);
    end
    bus.botoes_jogadores = 6'b000010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (bus.escolha_valida) strobes++;
    end
    n_checks++;
    if (strobes != 1 || bus.escolha_valida !== 1'b1 || bus.jogador_escolhido !== 3'b001) begin
      n_errors++;
      $display("FAIL repress: strobes=%0d v=%b idx=%b required strobes=1 v=1 idx=001",
               strobes, bus.escolha_valida, bus.jogador_escolhido);
    end
    bus.botoes_jogadores = '0;
    tick();
  endtask

  task automatic test_invalid();
    bus.limpa = 1'b1;
    tick();
    bus.limpa = 1'b0;
    n_checks++;
    if (bus.jogador_escolhido !== 3'b111 || bus.escolha_valida !== 1'b0) begin
      n_errors++;
      $display("FAIL limpa_idle: idx=%b v=%b required idx=111 v=0", bus.jogador_escolhido, bus.escolha_valida);
    end
    bus.botoes_jogadores = 6'b001001;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (bus.escolha_invalida !== 1'b1 || bus.escolha_valida !== 1'b0 || bus.jogador_escolhido !== 3'b111) begin
      n_errors++;
      $display("FAIL multi_press: i=%b v=%b idx=%b required i=1 v=0 idx=111",
               bus.escolha_invalida, bus.escolha_valida, bus.jogador_escolhido);
    end
    bus.botoes_jogadores = '0;
    tick();
    bus.jogadores_vivos = 5'b01111;
    bus.botoes_jogadores = 6'b010000;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (bus.escolha_invalida !== 1'b1 || bus.escolha_valida !== 1'b0 || bus.jogador_escolhido !== 3'b111) begin
      n_errors++;
      $display("FAIL dead_player: i=%b v=%b idx=%b required i=1 v=0 idx=111",
               bus.escolha_invalida, bus.escolha_valida, bus.jogador_escolhido);
    end
    tick();
    n_checks++;
    if (bus.escolha_invalida !== 1'b0) begin
      n_errors++;
      $display("FAIL invalid_one_cycle: i=%b required i=0", bus.escolha_invalida);
    end
    bus.botoes_jogadores = '0;
    bus.jogadores_vivos = 5'b11111;
    tick();
  endtask

  task automatic test_skip();
    bus.permite_pular = 1'b1;
    bus.botoes_jogadores = 6'b100000;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (bus.escolha_valida !== 1'b1 || bus.jogador_escolhido !== 3'b101) begin
      n_errors++;
      $display("FAIL skip_ok: v=%b idx=%b required v=1 idx=101", bus.escolha_valida, bus.jogador_escolhido);
    end
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.escolha_valida || bus.escolha_invalida) strobes++;
    end
    n_checks++;
    if (strobes != 0 || bus.ocupado !== 1'b1) begin
      n_errors++;
      $display("FAIL skip_hold: strobes=%0d oc=%b required strobes=0 oc=1", strobes, bus.ocupado);
    end
    bus.botoes_jogadores = '0;
    tick();
    bus.permite_pular = 1'b0;
    bus.botoes_jogadores = 6'b100000;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (bus.escolha_invalida !== 1'b1 || bus.jogador_escolhido !== 3'b101) begin
      n_errors++;
      $display("FAIL skip_denied: i=%b idx=%b required i=1 idx=101", bus.escolha_invalida, bus.jogador_escolhido);
    end
    bus.botoes_jogadores = '0;
    bus.permite_pular = 1'b1;
    tick();
  endtask

  task automatic test_limpa_and_abort();
    bus.botoes_jogadores = 6'b001000;
    tick(); tick(); tick();
    bus.limpa = 1'b1;
    tick();
    bus.limpa = 1'b0;
    n_checks++;
    if (bus.escolha_valida !== 1'b0 || bus.escolha_invalida !== 1'b0 ||
        bus.jogador_escolhido !== 3'b111 || bus.ocupado !== 1'b0) begin
      n_errors++;
      $display("FAIL limpa_decide: v=%b i=%b idx=%b oc=%b required v=0 i=0 idx=111 oc=0",
               bus.escolha_valida, bus.escolha_invalida, bus.jogador_escolhido, bus.ocupado);
    end
    bus.botoes_jogadores = '0;
    tick();
    strobes = 0;
    bus.botoes_jogadores = 6'b000001;
    tick(); tick();
    bus.habilita = 1'b0;
    tick();
    n_checks++;
    if (bus.ocupado !== 1'b0 || bus.estado_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL abort_state: oc=%b st=%0d required oc=0 st=0", bus.ocupado, bus.estado_dbg);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.escolha_valida || bus.escolha_invalida) strobes++;
    end
    n_checks++;
    if (strobes != 0 || bus.jogador_escolhido !== 3'b111) begin
      n_errors++;
      $display("FAIL abort_nostrobe: strobes=%0d idx=%b required strobes=0 idx=111", strobes, bus.jogador_escolhido);
    end
    bus.botoes_jogadores = '0;
    bus.habilita = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.botoes_jogadores = 6'b000001;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (bus.escolha_valida !== 1'b1 || bus.jogador_escolhido !== 3'b000) begin
      n_errors++;
      $display("FAIL b2b_first: v=%b idx=%b required v=1 idx=000", bus.escolha_valida, bus.jogador_escolhido);
    end
    bus.botoes_jogadores = '0;
    tick();
    bus.botoes_jogadores = 6'b000010;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (bus.escolha_valida !== 1'b1 || bus.jogador_escolhido !== 3'b001) begin
      n_errors++;
      $display("FAIL b2b_second: v=%b idx=%b required v=1 idx=001", bus.escolha_valida, bus.jogador_escolhido);
    end
    bus.botoes_jogadores = '0;
    tick();
  endtask

  task automatic test_d1_n8();
    bus2.botoes_jogadores = 9'h080;
    tick();
    n_checks++;
    if (bus2.escolha_valida !== 1'b1 || bus2.jogador_escolhido !== 4'b0111 || bus2.ocupado !== 1'b1) begin
      n_errors++;
      $display("FAIL d1_player7: v=%b idx=%b oc=%b required v=1 idx=0111 oc=1",
               bus2.escolha_valida, bus2.jogador_escolhido, bus2.ocupado);
    end
    bus2.botoes_jogadores = '0;
    tick();
    n_checks++;
    if (bus2.escolha_valida !== 1'b0 || bus2.ocupado !== 1'b0) begin
      n_errors++;
      $display("FAIL d1_release: v=%b oc=%b required v=0 oc=0", bus2.escolha_valida, bus2.ocupado);
    end
    bus2.botoes_jogadores = 9'h100;
    tick();
    n_checks++;
    if (bus2.escolha_valida !== 1'b1 || bus2.jogador_escolhido !== 4'b1000) begin
      n_errors++;
      $display("FAIL d1_skip: v=%b idx=%b required v=1 idx=1000", bus2.escolha_valida, bus2.jogador_escolhido);
    end
    tick();
    #2 rst2_n = 1'b0;
    #1;
    n_checks++;
    if (bus2.jogador_escolhido !== 4'b1111 || bus2.ocupado !== 1'b0 || bus2.escolha_valida !== 1'b0) begin
      n_errors++;
      $display("FAIL d1_async_reset: idx=%b oc=%b v=%b required idx=1111 oc=0 v=0",
               bus2.jogador_escolhido, bus2.ocupado, bus2.escolha_valida);
    end
    bus2.botoes_jogadores = '0;
    tick();
    rst2_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_valid_press();
    test_short_press();
    test_invalid();
    test_skip();
    test_limpa_and_abort();
    test_back_to_back();
    test_d1_n8();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
